// File: rtl/phase_tracker.sv
// Receive-side phase tracker: validates the one-hot 5-phase bus, re-issues
// registered stage enables, handles halt at instruction boundaries and counts retirements.
module phase_tracker #(
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [4:0]         phase_bus,
  input  logic               halt_req,
  input  logic               clear_fault,
  output logic [4:0]         stage_en,
  output logic               locked,
  output logic               halt_ack,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [2:0]         last_phase,
  output logic [COUNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               state_s;
  logic [4:0]           expected_r;
  logic [4:0]           expected_s;
  logic [4:0]           stage_en_s;
  logic [2:0]           last_phase_s;
  logic [COUNT_W-1:0]   count_s;
  logic [1:0]           code_s;
  logic                 accept_s;

  function automatic logic is_one_hot(input logic [4:0] p);
    return (p != 5'd0) && ((p & (p - 5'd1)) == 5'd0);
  endfunction

  // A one-hot value that is merely the wrong phase is an ordering error.
  function automatic logic [1:0] mismatch_code(input logic [4:0] p);
    return is_one_hot(p) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [2:0] phase_index(input logic [4:0] p);
    case (p)
      5'b00001: return 3'd0;
      5'b00010: return 3'd1;
      5'b00100: return 3'd2;
      5'b01000: return 3'd3;
      5'b10000: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

  // Next-state and next-output decode for the tracker FSM.
  always_comb begin
    state_s      = state_r;
    expected_s   = expected_r;
    stage_en_s   = 5'd0;
    last_phase_s = last_phase;
    count_s      = retired_count;
    code_s       = fault_code;
    accept_s     = (phase_bus == expected_r);
    case (state_r)
      IDLE: begin
        if (phase_bus == 5'b00001) begin
          state_s      = RUN;
          stage_en_s   = 5'b00001;
          expected_s   = 5'b00010;
          last_phase_s = 3'd0;
        end else begin
          state_s = IDLE;
        end
      end
      RUN, HALTED: begin
        if (accept_s) begin
          last_phase_s = phase_index(phase_bus);
          expected_s   = {expected_r[3:0], expected_r[4]};
          if (state_r == RUN) begin
            stage_en_s = phase_bus;
            if (phase_bus[4]) begin
              count_s = retired_count + COUNT_ONE;
              state_s = halt_req ? HALTED : RUN;
            end else begin
              state_s = RUN;
            end
          end else if (phase_bus[0] && !halt_req) begin
            state_s    = RUN;
            stage_en_s = 5'b00001;
          end else begin
            state_s = HALTED;
          end
        end else begin
          state_s = FAULT;
          code_s  = mismatch_code(phase_bus);
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_s    = IDLE;
          code_s     = 2'b00;
          expected_s = 5'b00001;
        end else begin
          state_s = FAULT;
        end
      end
      default: begin
        state_s    = IDLE;
        expected_s = 5'b00001;
      end
    endcase
  end

  // State and output registers; flags are registered from the next state so they track it exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      expected_r    <= 5'b00001;
      stage_en      <= 5'd0;
      locked        <= 1'b0;
      halt_ack      <= 1'b0;
      fault         <= 1'b0;
      fault_code    <= 2'b00;
      last_phase    <= 3'd0;
      retired_count <= {COUNT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      expected_r    <= expected_s;
      stage_en      <= stage_en_s;
      locked        <= (state_s == RUN) || (state_s == HALTED);
      halt_ack      <= (state_s == HALTED);
      fault         <= (state_s == FAULT);
      fault_code    <= code_s;
      last_phase    <= last_phase_s;
      retired_count <= count_s;
    end
  end

endmodule

// File: doc/phase_tracker.md
# phase_tracker

Receive-side companion to the processor phase controller. It consumes the one-hot 5-phase bus (fetch, decode, execute, memory, writeback), checks that the bus is one-hot and advances in order, and re-issues registered per-stage enables to the datapath. It also provides a halt handshake at instruction boundaries and a retired-instruction counter. It sits between the phase controller and the datapath stage registers.

## Interface
- COUNT_W, 16, width of retired-instruction counter
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- phase_bus  in  5  one-hot phase from controller; bit0 = fetch … bit4 = writeback
- halt_req  in  1  level request to stop at the next instruction boundary
- clear_fault  in  1  one-cycle pulse; leaves FAULT
- stage_en  out  5  registered copy of the accepted phase; 0 when not running
- locked  out  1  1 in RUN or HALTED
- halt_ack  out  1  1 while in HALTED
- fault  out  1  sticky error flag
- fault_code  out  2  01 = bus not one-hot, 10 = out-of-order phase, 00 = none
- last_phase  out  3  binary index (0–4) of the last accepted phase
- retired_count  out  COUNT_W  number of accepted writeback phases, modulo 2^COUNT_W

## Operation
- Internal `expected[4:0]` is one-hot. On acceptance it rotates left, with 10000 wrapping to 00001.
- States: IDLE, RUN, HALTED, FAULT.
- **IDLE**
  - stage_en = 0.
  - phase_bus == 00001: go to RUN, stage_en <= 00001, expected <= 00010, last_phase <= 0.
  - Any other value, including 00000 or invalid codes: stay in IDLE; no fault.
- **RUN**, phase_bus == expected (accept):
  - stage_en <= phase_bus.
  - last_phase <= index of phase_bus.
  - expected rotates.
  - If phase_bus == 10000: retired_count += 1. If halt_req == 1 in that same cycle, go to HALTED. The writeback stage_en pulse is still issued.
- **RUN**, phase_bus != expected:
  - Go to FAULT, stage_en <= 0.
  - fault_code <= 01 if phase_bus is not exactly one-hot (including 00000), otherwise 10.
- halt_req is sampled only on an accepted writeback. Asserting and then dropping it before writeback has no effect.
- **HALTED**
  - stage_en = 0; halt_ack = 1.
  - Sequence checking continues: matches rotate `expected`, mismatches go to FAULT with the same code rules.
  - Accepted fetch (00001) with halt_req == 0: go to RUN, stage_en <= 00001.
  - Accepted fetch with halt_req still 1: stay in HALTED.
  - retired_count does not change in HALTED.
- **FAULT**
  - stage_en = 0, fault = 1, fault_code held, phase_bus ignored.
  - clear_fault: go to IDLE and clear fault and fault_code. retired_count and last_phase keep their values.
- Reset has priority over clear_fault, which has priority over bus checking.

## Timing
- Reset values: state IDLE, expected 00001, stage_en 0, locked 0, halt_ack 0, fault 0, fault_code 00, last_phase 0, retired_count 0.
- stage_en, last_phase and retired_count update one cycle after phase_bus is sampled. Latency is exactly 1; no combinational path from phase_bus to any output.
- locked, halt_ack and fault decode from the registered state, so they change in the same cycle as the state change.
- The first fault is captured in one cycle, and the bad cycle produces no stage_en pulse.
- Reset mid-instruction: the next cycle is IDLE with all outputs at reset values. After reset the controller drives 00100, which IDLE ignores until 00001 appears.
- Reset-to-RUN: the controller reaches fetch 3 cycles after leaving reset. stage_en = 00001 appears 1 cycle after that.
- clear_fault asserted together with a valid 00001 gives IDLE that cycle. RUN can be entered on the next fetch.
- retired_count wraps from 2^COUNT_W−1 to 0 with no flag.

## Test plan
- **Lock-in:** release reset; the controller drives 00100, 01000, 10000, 00001, 00010… → stage_en stays 0 until one cycle after the first 00001, then tracks the bus delayed by 1. After 3 full instructions, retired_count = 3.
- **Halt handshake:** in RUN, raise halt_req during execute → the writeback pulse is still issued, retired_count increments, halt_ack = 1 from the next cycle, and stage_en = 0 for the following phases. Drop halt_req during decode → RUN resumes with stage_en = 00001 one cycle after the next fetch.
- **Fault, not one-hot:** in RUN, drive 00110 in place of 00100 → fault = 1, fault_code = 01, stage_en = 0, fault persists for 20 cycles. Pulse clear_fault → IDLE, fault = 0, and relock on the next 00001.
- **Fault, order:** in RUN after decode, drive 01000 → fault_code = 10. Separately, drive 00000 in RUN → fault_code = 01.
- **Counter wrap:** with COUNT_W = 4, run 17 instructions → retired_count = 1.
- **Reset mid-operation:** assert reset in the memory phase with halt_req = 1 → all outputs return to reset values next cycle, with no halt_ack and no retire increment.
